// File: rtl/learn_mode_sequencer_pkg.sv
// rtl/learn_mode_sequencer_pkg.sv - shared note-code boundaries, duration/octave/state enums
package learn_mode_sequencer_pkg;

  localparam int CODE_W = 6;

  // Codes fall into three 21-wide octave groups (mid, low, high); inside a group
  // offsets 1-7 are eighths, 8-14 quarters, 15-21 sixteenths. Code 0 is the rest.
  localparam logic [5:0] LOW_BASE      = 6'd21;
  localparam logic [5:0] HIGH_BASE     = 6'd42;
  localparam logic [5:0] QUARTER_OFS   = 6'd8;
  localparam logic [5:0] SIXTEENTH_OFS = 6'd15;

  typedef enum logic [1:0] {DUR_16, DUR_8, DUR_4} dur_e;

  typedef enum logic [1:0] {
    OCT_MID  = 2'd0,
    OCT_LOW  = 2'd1,
    OCT_HIGH = 2'd2
  } oct_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_KEY,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic [6:0] pitch_onehot(input logic [2:0] idx);
    return 7'b1000000 >> idx;
  endfunction

endpackage

// File: rtl/learn_mode_sequencer_note_decode.sv
// rtl/learn_mode_sequencer_note_decode.sv - note code to one-hot pitch, octave and duration class
module learn_mode_sequencer_note_decode
  import learn_mode_sequencer_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [6:0]        pitch,
  output oct_e              octave,
  output dur_e              dur,
  output logic              is_rest
);

  logic [5:0] rel;
  logic [2:0] idx;

  always_comb begin
    octave  = OCT_MID;
    rel     = code;
    dur     = DUR_8;
    idx     = 3'd0;
    pitch   = 7'd0;
    is_rest = (code == 6'd0);

    if (code > HIGH_BASE) begin
      octave = OCT_HIGH;
      rel    = code - HIGH_BASE;
    end else if (code > LOW_BASE) begin
      octave = OCT_LOW;
      rel    = code - LOW_BASE;
    end

    if (rel >= SIXTEENTH_OFS) begin
      dur = DUR_16;
      idx = 3'(rel - SIXTEENTH_OFS);
    end else if (rel >= QUARTER_OFS) begin
      dur = DUR_4;
      idx = 3'(rel - QUARTER_OFS);
    end else begin
      dur = DUR_8;
      idx = 3'(rel - 6'd1);
    end

    if (!is_rest)
      pitch = pitch_onehot(idx);
  end

endmodule

// File: rtl/learn_mode_sequencer.sv
// rtl/learn_mode_sequencer.sv - learn-mode playback FSM; LEARN_TIMEOUT_EN enables the key-wait timeout
module learn_mode_sequencer
  import learn_mode_sequencer_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int TICKS_16      = 5,
  parameter int TICKS_8       = 10,
  parameter int TICKS_4       = 20,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 200,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         song_sel,
  output logic               note_req,
  output logic [ADDR_W-1:0]  note_addr,
  output logic [1:0]         song_q,
  input  logic               note_ack,
  input  logic [CODE_W-1:0]  note_code,
  input  logic               note_last,
  input  logic               key_valid,
  input  logic [6:0]         key_lights,
  input  logic [1:0]         key_oct,
  output logic               play_en,
  output logic [CODE_W-1:0]  play_code,
  output logic [6:0]         lights,
  output logic               isHight,
  output logic               isLow,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses
);

  localparam int MAX_TICKS = (TIMEOUT_TICKS > TICKS_4) ? TIMEOUT_TICKS : TICKS_4;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  state_e              state, next_state;
  logic                entry;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    dur_last;
  logic [ADDR_W-1:0]   addr;
  logic [CODE_W-1:0]   code_q;
  logic                last_q;
  logic                missed;
  logic                count_en;
  logic                tick_counted;
  logic                key_match;
  logic                hit_inc;
  logic                miss_inc;

  logic [6:0]          exp_pitch;
  oct_e                exp_oct;
  dur_e                exp_dur;
  logic                exp_rest;

  learn_mode_sequencer_note_decode u_note_decode (
    .code    (code_q),
    .pitch   (exp_pitch),
    .octave  (exp_oct),
    .dur     (exp_dur),
    .is_rest (exp_rest)
  );

  always_comb begin
    case (exp_dur)
      DUR_16:  dur_last = CNT_W'(TICKS_16 - 1);
      DUR_4:   dur_last = CNT_W'(TICKS_4 - 1);
      default: dur_last = CNT_W'(TICKS_8 - 1);
    endcase
  end

`ifdef LEARN_TIMEOUT_EN
  assign count_en = (state == S_PLAY) || (state == S_GAP) || (state == S_WAIT_KEY);
`else
  assign count_en = (state == S_PLAY) || (state == S_GAP);
`endif

  // The first cycle of every state ignores tick so durations are whole ticks.
  assign tick_counted = tick && !entry && count_en;
  assign key_match    = (key_lights == exp_pitch) && (key_oct == exp_oct);

  always_comb begin
    next_state = state;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    case (state)
      S_IDLE:
        if (start) next_state = S_FETCH;
      S_FETCH:
        if (note_ack) next_state = (note_code == '0) ? S_PLAY : S_WAIT_KEY;
      S_WAIT_KEY: begin
        if (key_valid) begin
          if (key_match) begin
            next_state = S_PLAY;
            hit_inc    = !missed;
          end else begin
            miss_inc = 1'b1;
          end
        end
`ifdef LEARN_TIMEOUT_EN
        else if (tick_counted && cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
          next_state = S_PLAY;
          miss_inc   = 1'b1;
        end
`endif
      end
      S_PLAY:
        if (tick_counted && cnt == dur_last) next_state = S_GAP;
      S_GAP:
        if (tick_counted && cnt == CNT_W'(GAP_TICKS - 1))
          next_state = last_q ? S_DONE : S_FETCH;
      S_DONE:
        next_state = S_IDLE;
      default:
        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      state  <= S_IDLE;
      entry  <= 1'b0;
      cnt    <= '0;
      addr   <= '0;
      song_q <= '0;
      code_q <= '0;
      last_q <= 1'b0;
      missed <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        entry <= 1'b1;
        cnt   <= '0;
      end else begin
        entry <= 1'b0;
        if (tick_counted) cnt <= cnt + 1'b1;
      end
      if (state == S_IDLE && start) begin
        addr   <= '0;
        song_q <= song_sel;
      end
      if (state == S_FETCH && note_ack) begin
        code_q <= note_code;
        last_q <= note_last;
        missed <= 1'b0;
      end
      if (state == S_GAP && next_state == S_FETCH) addr <= addr + 1'b1;
      if (miss_inc) missed <= 1'b1;
    end
  end

  // Scores survive stop so the display can still show the aborted attempt.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits   <= '0;
      misses <= '0;
    end else if (!stop) begin
      if (state == S_IDLE && start) begin
        hits   <= '0;
        misses <= '0;
      end else begin
        if (hit_inc && hits != '1)    hits   <= hits + 1'b1;
        if (miss_inc && misses != '1) misses <= misses + 1'b1;
      end
    end
  end

  assign note_req  = (state == S_FETCH);
  assign note_addr = addr;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign play_en   = (state == S_PLAY) && !exp_rest;
  assign play_code = (state == S_PLAY) ? code_q : '0;
  assign lights    = (state == S_WAIT_KEY) ? exp_pitch : 7'd0;
  assign isHight   = (state == S_WAIT_KEY) && (exp_oct == OCT_HIGH);
  assign isLow     = (state == S_WAIT_KEY) && (exp_oct == OCT_LOW);

endmodule
